// File: rtl/ball_motion.sv
// Breakout ball engine: owns ball position/direction and reflects off walls, paddle and bricks.
// Optional BALL_SPEEDUP_EN: every 4th brick hit halves the tick period, floored at STEP_DIV>>2.
module ball_motion #(
  parameter int R_BALL     = 8,
  parameter int H_BAR      = 8,
  parameter int W_BAR      = 64,
  parameter int Y_BAR      = 440,
  parameter int STEP_DIV   = 250000,
  parameter int HOLD_TICKS = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       endgame,
  input  logic [9:0] x_bar,
  input  logic       hit_u,
  input  logic       hit_d,
  input  logic       hit_l,
  input  logic       hit_r,
  output logic [9:0] x_ball,
  output logic [9:0] y_ball,
  output logic [9:0] next_x,
  output logic [9:0] next_y,
  output logic       dir_x,
  output logic       dir_y,
  output logic       lost,
  output logic       bounced
);

  typedef enum logic [1:0] {S_IDLE, S_MOVE, S_HOLD, S_LOST} state_t;

  localparam int CNT_W  = $clog2(STEP_DIV + 1);
  localparam int HOLD_W = $clog2(HOLD_TICKS + 1);

  localparam logic [CNT_W-1:0]  C_STEP     = CNT_W'(STEP_DIV);
  localparam logic [HOLD_W-1:0] C_HOLD_END = HOLD_W'(HOLD_TICKS - 1);
  localparam logic [9:0]  C_X_MIN    = 10'(R_BALL);
  localparam logic [9:0]  C_X_MAX    = 10'(639 - R_BALL);
  localparam logic [9:0]  C_Y_MIN    = 10'(R_BALL);
  localparam logic [9:0]  C_Y_LOST   = 10'(479 - R_BALL);
  localparam logic [9:0]  C_Y_START  = 10'(Y_BAR - H_BAR - R_BALL);
  localparam logic [9:0]  C_Y_BAR    = 10'(Y_BAR);
  localparam logic [10:0] C_PAD_TOP  = 11'(Y_BAR - H_BAR);
  localparam logic [10:0] C_W_BAR    = 11'(W_BAR);
  localparam logic [10:0] C_R_BALL   = 11'(R_BALL);
  localparam logic [10:0] C_X_SCREEN = 11'd639;

  state_t             r_state;
  logic [CNT_W-1:0]   r_tickCnt;
  logic [HOLD_W-1:0]  r_holdCnt;
  logic [9:0]         r_xBall;
  logic [9:0]         r_yBall;
  logic               r_dirX;
  logic               r_dirY;
  logic               r_lost;
  logic               r_bounced;
  logic               r_startPrev;

  logic [CNT_W-1:0]   w_period;
  logic [CNT_W-1:0]   w_periodM1;
  logic               w_inFlight;
  logic               w_tick;
  logic               w_brickEn;
  logic               w_brickAny;
  logic [10:0]        w_xExt;
  logic [10:0]        w_barExt;
  logic [10:0]        w_padLeft;
  logic [10:0]        w_padRightSum;
  logic [10:0]        w_padRight;
  logic [10:0]        w_yBottom;
  logic               w_paddle;
  logic               w_padTaken;
  logic               w_newDirX;
  logic               w_newDirY;
  logic [9:0]         w_newX;
  logic [9:0]         w_newY;

`ifdef BALL_SPEEDUP_EN
  logic [2:0] r_hitCnt;
  logic [1:0] r_speed;

  assign w_period = C_STEP >> r_speed;
`else
  assign w_period = C_STEP;
`endif

  assign w_periodM1 = w_period - CNT_W'(1);
  assign w_inFlight = (r_state == S_MOVE) || (r_state == S_HOLD);
  // ">=" keeps the tick alive if the period shrinks below the running count
  assign w_tick     = w_inFlight && !endgame && (r_tickCnt >= w_periodM1);

  assign w_brickEn  = (r_state == S_MOVE);
  assign w_brickAny = w_brickEn && (hit_u || hit_d || hit_l || hit_r);

  assign w_xExt        = {1'b0, r_xBall};
  assign w_barExt      = {1'b0, x_bar};
  assign w_padLeft     = (w_barExt >= C_W_BAR) ? (w_barExt - C_W_BAR) : 11'd0;
  assign w_padRightSum = w_barExt + C_W_BAR;
  assign w_padRight    = (w_padRightSum > C_X_SCREEN) ? C_X_SCREEN : w_padRightSum;
  assign w_yBottom     = {1'b0, r_yBall} + C_R_BALL;

  assign w_paddle = r_dirY && (w_yBottom >= C_PAD_TOP) && (r_yBall <= C_Y_BAR) &&
                    (w_xExt >= w_padLeft) && (w_xExt <= w_padRight);

  // Per-axis priority: wall, then brick face, then paddle
  always_comb begin
    w_newDirX = r_dirX;
    if (r_xBall <= C_X_MIN)
      w_newDirX = 1'b1;
    else if (r_xBall >= C_X_MAX)
      w_newDirX = 1'b0;
    else if (w_brickEn && hit_l)
      w_newDirX = 1'b0;
    else if (w_brickEn && hit_r)
      w_newDirX = 1'b1;
  end

  always_comb begin
    w_newDirY  = r_dirY;
    w_padTaken = 1'b0;
    if (r_yBall <= C_Y_MIN)
      w_newDirY = 1'b1;
    else if (w_brickEn && hit_u)
      w_newDirY = 1'b0;
    else if (w_brickEn && hit_d)
      w_newDirY = 1'b1;
    else if (w_paddle) begin
      w_newDirY  = 1'b0;
      w_padTaken = 1'b1;
    end
  end

  assign w_newX = w_newDirX ? (r_xBall + 10'd1) : (r_xBall - 10'd1);
  assign w_newY = w_newDirY ? (r_yBall + 10'd1) : (r_yBall - 10'd1);

  always_ff @(posedge clock) begin
    if (!reset)
      r_tickCnt <= '0;
    else if (endgame)
      r_tickCnt <= r_tickCnt;
    else if (!w_inFlight || w_tick)
      r_tickCnt <= '0;
    else
      r_tickCnt <= r_tickCnt + CNT_W'(1);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_holdCnt   <= '0;
      r_xBall     <= x_bar;
      r_yBall     <= C_Y_START;
      r_dirX      <= 1'b1;
      r_dirY      <= 1'b0;
      r_lost      <= 1'b0;
      r_bounced   <= 1'b0;
      r_startPrev <= 1'b0;
`ifdef BALL_SPEEDUP_EN
      r_hitCnt    <= '0;
      r_speed     <= '0;
`endif
    end else begin
      r_bounced   <= 1'b0;
      r_startPrev <= start;
      if (!endgame) begin
        case (r_state)
          S_IDLE: begin
            r_xBall   <= x_bar;
            r_yBall   <= C_Y_START;
            r_dirX    <= 1'b1;
            r_dirY    <= 1'b0;
            r_lost    <= 1'b0;
            r_holdCnt <= '0;
`ifdef BALL_SPEEDUP_EN
            r_hitCnt  <= '0;
            r_speed   <= '0;
`endif
            if (start)
              r_state <= S_MOVE;
          end
          S_MOVE, S_HOLD: begin
            if (w_tick) begin
              if (r_yBall >= C_Y_LOST) begin
                r_state <= S_LOST;
                r_lost  <= 1'b1;
              end else begin
                r_dirX  <= w_newDirX;
                r_dirY  <= w_newDirY;
                r_xBall <= w_newX;
                r_yBall <= w_newY;
                if (r_state == S_MOVE) begin
                  if (w_brickAny || w_padTaken) begin
                    r_state   <= S_HOLD;
                    r_holdCnt <= '0;
                  end
                  if (w_brickAny) begin
                    r_bounced <= 1'b1;
`ifdef BALL_SPEEDUP_EN
                    if (r_hitCnt == 3'd3) begin
                      r_hitCnt <= '0;
                      if (r_speed != 2'd2)
                        r_speed <= r_speed + 2'd1;
                    end else begin
                      r_hitCnt <= r_hitCnt + 3'd1;
                    end
`endif
                  end
                end else begin
                  if (w_padTaken)
                    r_holdCnt <= '0;
                  else if (r_holdCnt == C_HOLD_END) begin
                    r_state   <= S_MOVE;
                    r_holdCnt <= '0;
                  end else
                    r_holdCnt <= r_holdCnt + HOLD_W'(1);
                end
              end
            end
          end
          S_LOST: begin
            r_lost <= 1'b1;
            if (start && !r_startPrev) begin
              r_state <= S_IDLE;
              r_lost  <= 1'b0;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign x_ball  = r_xBall;
  assign y_ball  = r_yBall;
  assign dir_x   = r_dirX;
  assign dir_y   = r_dirY;
  assign lost    = r_lost;
  assign bounced = r_bounced;
  assign next_x  = r_dirX ? (r_xBall + 10'd1) : (r_xBall - 10'd1);
  assign next_y  = r_dirY ? (r_yBall + 10'd1) : (r_yBall - 10'd1);

endmodule
